// File: rtl/lcd_cmd_issuer.sv
// lcd_cmd_issuer
//   Upstream command stage for the LCD image controller. Host opcodes are
//   screened for legality (0x0-0xB) and buffered in a DEPTH-entry FIFO. One
//   command at a time is issued to the controller, and only while it reports
//   not-busy. After an issue, the block waits for the controller to go busy.
//   It gives up after TIMEOUT cycles and drops that command. When the write
//   command (opcode 0) completes with a done pulse, the block parks in a
//   terminal state and reports sequence completion.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   host_cmd       opcode from host
//   host_valid     host_cmd valid this cycle
//   host_ready     block accepts host_cmd this cycle (combinational)
//   lcd_cmd        opcode to controller (registered, held after issue)
//   lcd_cmd_valid  single-cycle issue strobe (registered)
//   lcd_busy       controller busy
//   lcd_done       controller done pulse
//   fifo_count     commands currently buffered
//   issued_cnt     commands issued since reset, 8-bit wrap
//   seq_done       sticky: write command completed
//   err_drop       one-cycle pulse: illegal opcode consumed and dropped
//   err_timeout    one-cycle pulse: controller never went busy after issue

module lcd_cmd_issuer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [3:0]               lcd_cmd,
  output logic                     lcd_cmd_valid,
  input  logic                     lcd_busy,
  input  logic                     lcd_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               issued_cnt,
  output logic                     seq_done,
  output logic                     err_drop,
  output logic                     err_timeout
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
  // Last value of the wait counter before the timeout fires.
  localparam logic [ToW-1:0]  ToLast    = ToW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StWait,
    StAck,
    StBusy,
    StFin
  } state_e;

  state_e            state_q;

  // FIFO storage and bookkeeping
  logic [3:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;

  // Registered outputs and tracking state
  logic [3:0]        lcd_cmd_q;
  logic              lcd_cmd_valid_q;
  logic [7:0]        issued_cnt_q;
  logic              seq_done_q;
  logic              err_drop_q;
  logic              err_timeout_q;
  logic [ToW-1:0]    to_cnt_q;
  logic              done_seen_q;

  logic              cmd_legal;
  logic              push;
  logic              push_legal;
  logic              pop;

  //--------------------------------------------------------------------------
  // Handshake decode
  //--------------------------------------------------------------------------
  assign cmd_legal  = (host_cmd < 4'hC);
  // Readiness ignores a same-cycle pop, so a full FIFO stalls the host for a
  // cycle even when a command is leaving.
  assign host_ready = (count_q < FullCount) && (state_q != StFin);
  assign push       = host_valid && host_ready;
  assign push_legal = push && cmd_legal;
  // Popping only from StWait with busy low means the issue strobe always
  // follows a cycle in which the controller was idle.
  assign pop        = (state_q == StWait) && !lcd_busy && (count_q != '0);

  //--------------------------------------------------------------------------
  // FIFO
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_legal) begin
      mem_q[wr_ptr_q] <= host_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_legal) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push_legal, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Issue FSM with registered outputs
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StWait;
      lcd_cmd_q       <= 4'h0;
      lcd_cmd_valid_q <= 1'b0;
      issued_cnt_q    <= 8'd0;
      seq_done_q      <= 1'b0;
      err_drop_q      <= 1'b0;
      err_timeout_q   <= 1'b0;
      to_cnt_q        <= '0;
      done_seen_q     <= 1'b0;
    end else begin
      // Pulse outputs default low.
      lcd_cmd_valid_q <= 1'b0;
      err_timeout_q   <= 1'b0;
      err_drop_q      <= push && !cmd_legal;

      case (state_q)
        StWait: begin
          if (pop) begin
            lcd_cmd_q       <= mem_q[rd_ptr_q];
            lcd_cmd_valid_q <= 1'b1;
            issued_cnt_q    <= issued_cnt_q + 8'd1;
            to_cnt_q        <= '0;
            done_seen_q     <= 1'b0;
            state_q         <= StAck;
          end
        end

        StAck: begin
          if (lcd_done) begin
            done_seen_q <= 1'b1;
          end
          if (lcd_busy) begin
            state_q <= StBusy;
          end else if (to_cnt_q == ToLast) begin
            // Controller never acknowledged; the command is abandoned.
            err_timeout_q <= 1'b1;
            state_q       <= StWait;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end

        StBusy: begin
          if (lcd_done) begin
            done_seen_q <= 1'b1;
          end
          if (!lcd_busy) begin
            // A done pulse coincident with busy falling still counts.
            if ((lcd_cmd_q == 4'h0) && (done_seen_q || lcd_done)) begin
              seq_done_q <= 1'b1;
              state_q    <= StFin;
            end else begin
              state_q <= StWait;
            end
          end
        end

        StFin: begin
          seq_done_q <= 1'b1;
        end

        default: begin
          state_q <= StWait;
        end
      endcase
    end
  end

  assign lcd_cmd       = lcd_cmd_q;
  assign lcd_cmd_valid = lcd_cmd_valid_q;
  assign fifo_count    = count_q;
  assign issued_cnt    = issued_cnt_q;
  assign seq_done      = seq_done_q;
  assign err_drop      = err_drop_q;
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Self-checking bench for lcd_cmd_issuer (DEPTH=8, TIMEOUT=15).
// Inputs are driven on the falling edge, and outputs are sampled 1 ns after the
// rising edge that consumed them.

module tb_lcd_cmd_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_done;
  logic [3:0] fifo_count;
  logic [7:0] issued_cnt;
  logic       seq_done;
  logic       err_drop;
  logic       err_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_cmd_issuer #(
    .DEPTH   (8),
    .TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .fifo_count    (fifo_count),
    .issued_cnt    (issued_cnt),
    .seq_done      (seq_done),
    .err_drop      (err_drop),
    .err_timeout   (err_timeout)
  );

  typedef struct {
    logic       rst;
    logic       hv;
    logic [3:0] hc;
    logic       busy;
    logic       done;
    logic       ev;
    logic [3:0] ecmd;
    logic [3:0] ecnt;
    logic [7:0] eiss;
    logic       esd;
    logic       eed;
    logic       eet;
    logic       erdy;
  } vec_t;

  localparam int NumVec = 48;
  vec_t vecs [NumVec];

  function automatic vec_t mk(logic rst, logic hv, logic [3:0] hc, logic busy, logic done,
                              logic ev, logic [3:0] ecmd, logic [3:0] ecnt, logic [7:0] eiss,
                              logic esd, logic eed, logic eet, logic erdy);
    vec_t v;
    v.rst = rst;  v.hv = hv;     v.hc = hc;     v.busy = busy; v.done = done;
    v.ev  = ev;   v.ecmd = ecmd; v.ecnt = ecnt; v.eiss = eiss;
    v.esd = esd;  v.eed = eed;   v.eet = eet;   v.erdy = erdy;
    return v;
  endfunction

  // One clock: drive on the falling edge, return just after the rising edge.
  task automatic drive(input logic rst, input logic hv, input logic [3:0] hc,
                       input logic busy, input logic done);
    @(negedge clk);
    reset      = rst;
    host_valid = hv;
    host_cmd   = hc;
    lcd_busy   = busy;
    lcd_done   = done;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [3:0] ecmd,
                         input logic [3:0] ecnt, input logic [7:0] eiss, input logic esd,
                         input logic eed, input logic eet, input logic erdy);
    checks++;
    if (lcd_cmd_valid !== ev || lcd_cmd !== ecmd || fifo_count !== ecnt ||
        issued_cnt !== eiss || seq_done !== esd || err_drop !== eed ||
        err_timeout !== eet || host_ready !== erdy) begin
      errors++;
      $display("FAIL %s: got v=%b cmd=%h cnt=%0d iss=%0d sd=%b ed=%b et=%b rdy=%b ; want v=%b cmd=%h cnt=%0d iss=%0d sd=%b ed=%b et=%b rdy=%b",
               tag, lcd_cmd_valid, lcd_cmd, fifo_count, issued_cnt, seq_done, err_drop,
               err_timeout, host_ready, ev, ecmd, ecnt, eiss, esd, eed, eet, erdy);
    end
  endtask

  task automatic chk1(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  initial begin
    int saw_valid;

    reset      = 1'b1;
    host_valid = 1'b0;
    host_cmd   = 4'h0;
    lcd_busy   = 1'b0;
    lcd_done   = 1'b0;

    //                rst hv hc    bsy dn | v  cmd   cnt   iss  sd ed et rdy
    // Ordered drain of 5,7,9, with the controller busy for 3 cycles after each issue.
    vecs[0]  = mk(1, 0, 4'h0, 0, 0,  0, 4'h0, 4'd0, 8'd0, 0, 0, 0, 1);
    vecs[1]  = mk(0, 1, 4'h5, 0, 0,  0, 4'h0, 4'd1, 8'd0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 1, 4'h7, 0, 0,  1, 4'h5, 4'd1, 8'd1, 0, 0, 0, 1);
    vecs[3]  = mk(0, 1, 4'h9, 0, 0,  0, 4'h5, 4'd2, 8'd1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 4'h0, 1, 0,  0, 4'h5, 4'd2, 8'd1, 0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 4'h0, 1, 0,  0, 4'h5, 4'd2, 8'd1, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0, 4'h0, 1, 0,  0, 4'h5, 4'd2, 8'd1, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 4'h0, 0, 0,  0, 4'h5, 4'd2, 8'd1, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 4'h0, 0, 0,  1, 4'h7, 4'd1, 8'd2, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 4'h0, 0, 0,  0, 4'h7, 4'd1, 8'd2, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 4'h0, 1, 0,  0, 4'h7, 4'd1, 8'd2, 0, 0, 0, 1);
    vecs[11] = mk(0, 0, 4'h0, 1, 0,  0, 4'h7, 4'd1, 8'd2, 0, 0, 0, 1);
    vecs[12] = mk(0, 0, 4'h0, 1, 0,  0, 4'h7, 4'd1, 8'd2, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 4'h0, 0, 0,  0, 4'h7, 4'd1, 8'd2, 0, 0, 0, 1);
    vecs[14] = mk(0, 0, 4'h0, 0, 0,  1, 4'h9, 4'd0, 8'd3, 0, 0, 0, 1);
    vecs[15] = mk(0, 0, 4'h0, 0, 0,  0, 4'h9, 4'd0, 8'd3, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 4'h0, 1, 0,  0, 4'h9, 4'd0, 8'd3, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 4'h0, 1, 0,  0, 4'h9, 4'd0, 8'd3, 0, 0, 0, 1);
    vecs[18] = mk(0, 0, 4'h0, 1, 0,  0, 4'h9, 4'd0, 8'd3, 0, 0, 0, 1);
    vecs[19] = mk(0, 0, 4'h0, 0, 0,  0, 4'h9, 4'd0, 8'd3, 0, 0, 0, 1);
    // Write completion: 2, 0, 4; done arrives during the write's busy window.
    vecs[20] = mk(0, 1, 4'h2, 0, 0,  0, 4'h9, 4'd1, 8'd3, 0, 0, 0, 1);
    vecs[21] = mk(0, 1, 4'h0, 0, 0,  1, 4'h2, 4'd1, 8'd4, 0, 0, 0, 1);
    vecs[22] = mk(0, 1, 4'h4, 0, 0,  0, 4'h2, 4'd2, 8'd4, 0, 0, 0, 1);
    vecs[23] = mk(0, 0, 4'h0, 1, 0,  0, 4'h2, 4'd2, 8'd4, 0, 0, 0, 1);
    vecs[24] = mk(0, 0, 4'h0, 1, 0,  0, 4'h2, 4'd2, 8'd4, 0, 0, 0, 1);
    vecs[25] = mk(0, 0, 4'h0, 0, 0,  0, 4'h2, 4'd2, 8'd4, 0, 0, 0, 1);
    vecs[26] = mk(0, 0, 4'h0, 0, 0,  1, 4'h0, 4'd1, 8'd5, 0, 0, 0, 1);
    vecs[27] = mk(0, 0, 4'h0, 0, 0,  0, 4'h0, 4'd1, 8'd5, 0, 0, 0, 1);
    vecs[28] = mk(0, 0, 4'h0, 1, 0,  0, 4'h0, 4'd1, 8'd5, 0, 0, 0, 1);
    vecs[29] = mk(0, 0, 4'h0, 1, 1,  0, 4'h0, 4'd1, 8'd5, 0, 0, 0, 1);
    vecs[30] = mk(0, 0, 4'h0, 1, 0,  0, 4'h0, 4'd1, 8'd5, 0, 0, 0, 1);
    vecs[31] = mk(0, 0, 4'h0, 0, 0,  0, 4'h0, 4'd1, 8'd5, 1, 0, 0, 0);
    vecs[32] = mk(0, 1, 4'h3, 0, 0,  0, 4'h0, 4'd1, 8'd5, 1, 0, 0, 0);
    vecs[33] = mk(0, 0, 4'h0, 0, 0,  0, 4'h0, 4'd1, 8'd5, 1, 0, 0, 0);
    // Reset while busy with 3 commands buffered.
    vecs[34] = mk(1, 0, 4'h0, 0, 0,  0, 4'h0, 4'd0, 8'd0, 0, 0, 0, 1);
    vecs[35] = mk(0, 1, 4'h1, 0, 0,  0, 4'h0, 4'd1, 8'd0, 0, 0, 0, 1);
    vecs[36] = mk(0, 1, 4'h2, 0, 0,  1, 4'h1, 4'd1, 8'd1, 0, 0, 0, 1);
    vecs[37] = mk(0, 1, 4'h3, 0, 0,  0, 4'h1, 4'd2, 8'd1, 0, 0, 0, 1);
    vecs[38] = mk(0, 1, 4'h4, 1, 0,  0, 4'h1, 4'd3, 8'd1, 0, 0, 0, 1);
    vecs[39] = mk(1, 0, 4'h0, 1, 0,  0, 4'h0, 4'd0, 8'd0, 0, 0, 0, 1);
    vecs[40] = mk(0, 0, 4'h0, 0, 0,  0, 4'h0, 4'd0, 8'd0, 0, 0, 0, 1);
    // Write whose done pulse coincides with busy falling.
    vecs[41] = mk(0, 1, 4'h0, 0, 0,  0, 4'h0, 4'd1, 8'd0, 0, 0, 0, 1);
    vecs[42] = mk(0, 0, 4'h0, 0, 0,  1, 4'h0, 4'd0, 8'd1, 0, 0, 0, 1);
    vecs[43] = mk(0, 0, 4'h0, 1, 0,  0, 4'h0, 4'd0, 8'd1, 0, 0, 0, 1);
    vecs[44] = mk(0, 0, 4'h0, 0, 1,  0, 4'h0, 4'd0, 8'd1, 1, 0, 0, 0);
    // Illegal opcode into an empty FIFO.
    vecs[45] = mk(1, 0, 4'h0, 0, 0,  0, 4'h0, 4'd0, 8'd0, 0, 0, 0, 1);
    vecs[46] = mk(0, 1, 4'hE, 0, 0,  0, 4'h0, 4'd0, 8'd0, 0, 1, 0, 1);
    vecs[47] = mk(0, 0, 4'h0, 0, 0,  0, 4'h0, 4'd0, 8'd0, 0, 0, 0, 1);

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].rst, vecs[i].hv, vecs[i].hc, vecs[i].busy, vecs[i].done);
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ecmd, vecs[i].ecnt, vecs[i].eiss,
              vecs[i].esd, vecs[i].eed, vecs[i].eet, vecs[i].erdy);
    end

    // Start-up hold: busy high for 70 cycles, push 0x1 at cycle 3.
    drive(1, 0, 4'h0, 1, 0);
    saw_valid = 0;
    for (int c = 1; c <= 70; c++) begin
      drive(0, (c == 3), 4'h1, 1, 0);
      if (lcd_cmd_valid) saw_valid++;
    end
    chk1("hold_no_valid", saw_valid, 0);
    chk1("hold_count", int'(fifo_count), 1);
    drive(0, 0, 4'h0, 0, 0);
    chk_all("hold_issue", 1, 4'h1, 4'd0, 8'd1, 0, 0, 0, 1);
    drive(0, 0, 4'h0, 1, 0);
    chk_all("hold_one_cycle", 0, 4'h1, 4'd0, 8'd1, 0, 0, 0, 1);

    // FIFO full: push 10 legal commands while the controller stays busy.
    drive(1, 0, 4'h0, 1, 0);
    saw_valid = 0;
    for (int i = 0; i < 10; i++) begin
      logic [3:0] op;
      op = 4'(i);
      drive(0, 1, op, 1, 0);
      if (lcd_cmd_valid) saw_valid++;
      if (i == 7) chk1("full_ready_after_8", int'(host_ready), 0);
    end
    chk1("full_count", int'(fifo_count), 8);
    chk1("full_ready", int'(host_ready), 0);
    chk1("full_no_valid", saw_valid, 0);
    drive(0, 0, 4'h0, 0, 0);
    chk_all("full_first_out", 1, 4'h0, 4'd7, 8'd1, 0, 0, 0, 1);

    // Timeout: issue 0x3 with busy held low; 0x6 waits behind it.
    drive(1, 0, 4'h0, 0, 0);
    drive(0, 1, 4'h3, 0, 0);
    drive(0, 0, 4'h0, 0, 0);
    chk_all("to_issue", 1, 4'h3, 4'd0, 8'd1, 0, 0, 0, 1);
    for (int k = 1; k <= 15; k++) begin
      drive(0, (k == 1), 4'h6, 0, 0);
      chk1($sformatf("to_pulse_k%0d", k), int'(err_timeout), (k == 15) ? 1 : 0);
    end
    drive(0, 0, 4'h0, 0, 0);
    chk_all("to_next_issue", 1, 4'h6, 4'd0, 8'd2, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
